dma_copy: RTL

Word-granular memory-to-memory copy engine for the on-chip bus. It is a bus responder for its four configuration registers (bank 0x04) and a bus initiator on a second master port that the top-level arbiter shares with the CPU. Software programs source, destination and length, sets start, and polls busy/done or takes `irq`. All copies are 32-bit word transfers with `m_sel_o` = 4'hF.

---
 rtl/dma_copy.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine.
//
// Responder port (adr_i, dat_i, sel_i, we_i, stb_i -> ack_o, dat_o):
//   0x0 SRC, 0x4 DST, 0x8 LEN (remaining words), 0xC CTRL.
//   CTRL write: bit0 start, bit1 ie, bit2 clear done, bit3 abort.
//   CTRL read:  bit0 busy, bit1 ie, bit2 done.
// Initiator port (m_adr_o, m_dat_o, m_dat_i, m_sel_o, m_we_o, m_stb_o, m_ack_i):
//   One full-word transaction outstanding at a time: read SRC, then write DST.
// irq: level interrupt, registered done & ie.
module dma_copy #(
  parameter int unsigned LEN_W = 16
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [3:0]  adr_i,
  input  logic [31:0] dat_i,
  input  logic [3:0]  sel_i,
  input  logic        we_i,
  input  logic        stb_i,
  output logic        ack_o,
  output logic [31:0] dat_o,
  output logic [31:0] m_adr_o,
  output logic [31:0] m_dat_o,
  input  logic [31:0] m_dat_i,
  output logic [3:0]  m_sel_o,
  output logic        m_we_o,
  output logic        m_stb_o,
  input  logic        m_ack_i,
  output logic        irq
);

  typedef enum logic [2:0] {StIdle, StRd, StWSetup, StWr, StRSetup} state_e;

  state_e           state_q;
  logic [31:0]      src_q, dst_q, buf_q;
  logic [LEN_W-1:0] len_q;
  logic             ie_q, done_q, abort_q, irq_q, ack_q;
  logic [31:0]      dat_q;
  logic [31:0]      m_adr_q, m_dat_q;
  logic [3:0]       m_sel_q;
  logic             m_we_q, m_stb_q;

  logic             busy, acc, wr_acc, ctrl_wr;
  logic             start_req, clr_req, abort_req, abort_now;
  logic [31:0]      byte_mask, rd_data, src_wdata, dst_wdata;
  logic [LEN_W-1:0] len_wdata;
  logic             unused_adr;

  assign unused_adr = ^adr_i[1:0];

  assign busy    = (state_q != StIdle);
  // The access is serviced on the edge that raises ack_o.
  assign acc     = stb_i & ~ack_q;
  assign wr_acc  = acc & we_i;
  assign ctrl_wr = wr_acc & (adr_i[3:2] == 2'd3) & sel_i[0];

  assign start_req = ctrl_wr & dat_i[0];
  assign clr_req   = ctrl_wr & dat_i[2];
  assign abort_req = ctrl_wr & dat_i[3] & busy;
  // An abort written on the same edge as a bus ack still takes effect there.
  assign abort_now = abort_q | abort_req;

  assign byte_mask = {{8{sel_i[3]}}, {8{sel_i[2]}}, {8{sel_i[1]}}, {8{sel_i[0]}}};
  assign src_wdata = ((src_q & ~byte_mask) | (dat_i & byte_mask)) & 32'hFFFF_FFFC;
  assign dst_wdata = ((dst_q & ~byte_mask) | (dat_i & byte_mask)) & 32'hFFFF_FFFC;
  assign len_wdata = (len_q & ~byte_mask[LEN_W-1:0]) | (dat_i[LEN_W-1:0] & byte_mask[LEN_W-1:0]);

  always_comb begin
    rd_data = '0;
    case (adr_i[3:2])
      2'd0:    rd_data = src_q;
      2'd1:    rd_data = dst_q;
      2'd2:    rd_data = 32'(len_q);
      default: rd_data = {29'd0, done_q, ie_q, busy};
    endcase
  end

  // Responder handshake: single-cycle ack, read data only while ack is high.
  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      ack_q <= 1'b0;
      dat_q <= '0;
    end else begin
      ack_q <= acc;
      dat_q <= (acc & ~we_i) ? rd_data : '0;
    end
  end

  always_ff @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      src_q   <= '0;
      dst_q   <= '0;
      len_q   <= '0;
      buf_q   <= '0;
      ie_q    <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      irq_q   <= 1'b0;
      m_adr_q <= '0;
      m_dat_q <= '0;
      m_sel_q <= '0;
      m_we_q  <= 1'b0;
      m_stb_q <= 1'b0;
    end else begin
      irq_q <= done_q & ie_q;
      if (ctrl_wr)   ie_q    <= dat_i[1];
      if (clr_req)   done_q  <= 1'b0;
      if (abort_req) abort_q <= 1'b1;

      // Later assignments below override the clear above, so completion wins.
      unique case (state_q)
        StIdle: begin
          abort_q <= 1'b0;
          if (wr_acc && adr_i[3:2] == 2'd0) src_q <= src_wdata;
          if (wr_acc && adr_i[3:2] == 2'd1) dst_q <= dst_wdata;
          if (wr_acc && adr_i[3:2] == 2'd2) len_q <= len_wdata;
          if (start_req) begin
            if (len_q != '0) begin
              done_q  <= 1'b0;
              state_q <= StRd;
              m_stb_q <= 1'b1;
              m_we_q  <= 1'b0;
              m_adr_q <= src_q;
              m_sel_q <= 4'hF;
            end else begin
              done_q <= 1'b1;
            end
          end
        end
        StRd: begin
          if (m_ack_i) begin
            buf_q   <= m_dat_i;
            src_q   <= src_q + 32'd4;
            m_stb_q <= 1'b0;
            m_sel_q <= 4'h0;
            if (abort_now) begin
              state_q <= StIdle;
              abort_q <= 1'b0;
            end else begin
              state_q <= StWSetup;
            end
          end
        end
        StWSetup: begin
          if (abort_now) begin
            state_q <= StIdle;
            abort_q <= 1'b0;
          end else begin
            state_q <= StWr;
            m_stb_q <= 1'b1;
            m_we_q  <= 1'b1;
            m_adr_q <= dst_q;
            m_dat_q <= buf_q;
            m_sel_q <= 4'hF;
          end
        end
        StWr: begin
          if (m_ack_i) begin
            dst_q   <= dst_q + 32'd4;
            len_q   <= len_q - LEN_W'(1);
            m_stb_q <= 1'b0;
            m_we_q  <= 1'b0;
            m_sel_q <= 4'h0;
            if (len_q == LEN_W'(1)) begin
              state_q <= StIdle;
              done_q  <= 1'b1;
              abort_q <= 1'b0;
            end else if (abort_now) begin
              state_q <= StIdle;
              abort_q <= 1'b0;
            end else begin
              state_q <= StRSetup;
            end
          end
        end
        StRSetup: begin
          if (abort_now) begin
            state_q <= StIdle;
            abort_q <= 1'b0;
          end else begin
            state_q <= StRd;
            m_stb_q <= 1'b1;
            m_we_q  <= 1'b0;
            m_adr_q <= src_q;
            m_sel_q <= 4'hF;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ack_o   = ack_q;
  assign dat_o   = dat_q;
  assign m_adr_o = m_adr_q;
  assign m_dat_o = m_dat_q;
  assign m_sel_o = m_sel_q;
  assign m_we_o  = m_we_q;
  assign m_stb_o = m_stb_q;
  assign irq     = irq_q;

endmodule
